// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - instruction fetch and issue sequencer feeding the uOP decoder
//
// Fetches an opcode byte from program memory at ip, then a trailing immediate
// byte when the opcode carries one, and presents both to the decoder. Jumps
// (0x80) and HALT (0xFE) are executed here on acceptance.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   run            level enable, sampled only when a new fetch could start
//   mem_req        read request, held until mem_rvalid
//   mem_addr       read address (always ip)
//   mem_rdata      read data, qualified by mem_rvalid
//   mem_rvalid     one-cycle read-complete strobe
//   issue_ready    downstream accepts the issued instruction this cycle
//   instruction    opcode to decoder, 8'hFF whenever instr_valid is low
//   instr_valid    instruction/imm_data valid
//   imm_data       immediate byte, 8'h00 when the opcode has none
//   ip             current instruction pointer
//   halted         high once HALT has been accepted
module instr_fetch_seq #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  input  logic              issue_ready,
  output logic [7:0]        instruction,
  output logic              instr_valid,
  output logic [7:0]        imm_data,
  output logic [ADDR_W-1:0] ip,
  output logic              halted
);

  localparam logic [7:0] OP_JUMP = 8'h80;
  localparam logic [7:0] OP_HALT = 8'hFE;
  localparam logic [7:0] OP_NOP  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_IMM,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] opcode_q;
  logic [7:0] imm_q;

  // Load-immediate, ALU-with-immediate and jump all carry a second byte.
  function automatic logic needs_imm(input logic [7:0] op);
    return (op[7:3] == 5'b00000) || (op[7:6] == 2'b01) || (op == OP_JUMP);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ip       <= RESET_IP;
      opcode_q <= OP_NOP;
      imm_q    <= 8'h00;
    end else begin
      state <= state_n;
      case (state)
        S_FETCH_OP: begin
          if (mem_rvalid) begin
            opcode_q <= mem_rdata;
            // Cleared here so single-byte opcodes present a zero immediate.
            imm_q    <= 8'h00;
            ip       <= ip + ADDR_W'(1);
          end
        end
        S_FETCH_IMM: begin
          if (mem_rvalid) begin
            imm_q <= mem_rdata;
            ip    <= ip + ADDR_W'(1);
          end
        end
        S_ISSUE: begin
          // Jump target replaces the already-incremented ip.
          if (issue_ready && (opcode_q == OP_JUMP)) begin
            ip <= ADDR_W'(imm_q);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    mem_req     = 1'b0;
    mem_addr    = ip;
    instr_valid = 1'b0;
    instruction = OP_NOP;
    imm_data    = 8'h00;
    halted      = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_n = S_FETCH_OP;
        end
      end
      S_FETCH_OP: begin
        mem_req = 1'b1;
        if (mem_rvalid) begin
          state_n = needs_imm(mem_rdata) ? S_FETCH_IMM : S_ISSUE;
        end
      end
      S_FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_rvalid) begin
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        instruction = opcode_q;
        imm_data    = imm_q;
        if (issue_ready) begin
          if (opcode_q == OP_HALT) begin
            state_n = S_HALTED;
          end else if (run) begin
            state_n = S_FETCH_OP;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - directed self-checking bench for instr_fetch_seq
module tb_instr_fetch_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_rvalid = 1'b0;
  logic       issue_ready = 1'b1;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [7:0] imm_data;
  logic [7:0] ip;
  logic       halted;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [256];
  int         lat = 1;
  logic       pend = 1'b0;
  int         remaining = 0;
  logic [7:0] addr_l = 8'h00;

  instr_fetch_seq #(.ADDR_W(8), .RESET_IP(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .issue_ready(issue_ready),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .imm_data   (imm_data),
    .ip         (ip),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Program memory with a fixed latency of lat cycles; deliberately not reset
  // so an in-flight read completes after a DUT reset.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (pend) begin
      if (remaining == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[addr_l];
        pend       <= 1'b0;
      end
      remaining <= remaining - 1;
    end else if (mem_req && !mem_rvalid) begin
      if (lat == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[mem_addr];
      end else begin
        pend      <= 1'b1;
        addr_l    <= mem_addr;
        remaining <= lat - 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
  endtask

  task automatic do_reset();
    run         = 1'b0;
    issue_ready = 1'b1;
    lat         = 1;
    rst         = 1'b1;
    fill_mem();
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for the next issue; lat_exp counts negedges from the call to the
  // first issue cycle and nreq counts completed reads on the way (0 = skip).
  task automatic wait_issue(input string tag, input logic [7:0] op, input logic [7:0] imm,
                            input int lat_exp, input int nreq);
    int  k;
    int  reqs;
    bit  seen;
    k = 0; reqs = 0; seen = 1'b0;
    while (!seen && k < 50) begin
      @(negedge clk);
      k++;
      if (mem_req && mem_rvalid) reqs++;
      if (instr_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_instr"}, instruction, op);
      chk({tag, "_imm"}, imm_data, imm);
      if (lat_exp > 0) chk({tag, "_latency"}, k, lat_exp);
      if (nreq > 0) chk({tag, "_reads"}, reqs, nreq);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 8'h00);
    chk({tag, "_instr"}, instruction, 8'hFF);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_imm"}, imm_data, 8'h00);
    chk({tag, "_ip"}, ip, 8'h00);
    chk({tag, "_halted"}, halted, 1'b0);
  endtask

  initial begin
    int cnt;
    fill_mem();
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Single-byte opcodes, NOP included; 3-cycle minimum latency.
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'hFF;
    run = 1'b1;
    wait_issue("t1_op0", 8'h10, 8'h00, 3, 1);
    @(negedge clk);
    chk("t1_gap_instr", instruction, 8'hFF);
    chk("t1_gap_valid", instr_valid, 1'b0);
    chk("t1_b2b_req", mem_req, 1'b1);
    wait_issue("t1_op1", 8'hFF, 8'h00, 2, 1);
    chk("t1_ip", ip, 8'h02);
    run = 1'b0;

    // Immediate-carrying opcodes; 5-cycle minimum latency, two reads each.
    do_reset();
    mem[8'h00] = 8'h02;
    mem[8'h01] = 8'hA5;
    mem[8'h02] = 8'h45;
    mem[8'h03] = 8'h3C;
    run = 1'b1;
    wait_issue("t2_op0", 8'h02, 8'hA5, 5, 2);
    wait_issue("t2_op1", 8'h45, 8'h3C, 5, 2);
    chk("t2_ip", ip, 8'h04);
    run = 1'b0;

    // Jump then HALT.
    do_reset();
    mem[8'h00] = 8'h80;
    mem[8'h01] = 8'h10;
    mem[8'h10] = 8'hFE;
    run = 1'b1;
    wait_issue("t3_jump", 8'h80, 8'h10, 5, 2);
    @(negedge clk);
    chk("t3_target_req", mem_req, 1'b1);
    chk("t3_target_addr", mem_addr, 8'h10);
    wait_issue("t3_halt", 8'hFE, 8'h00, 2, 1);
    @(negedge clk);
    chk("t3_halted", halted, 1'b1);
    chk("t3_halt_valid", instr_valid, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req || !halted) cnt++;
    end
    chk("t3_halt_quiet", cnt, 0);

    // Jump to its own address (spin loop).
    do_reset();
    mem[8'h00] = 8'h80;
    mem[8'h01] = 8'h00;
    run = 1'b1;
    wait_issue("t3_spin", 8'h80, 8'h00, 5, 2);
    @(negedge clk);
    chk("t3_spin_addr", mem_addr, 8'h00);
    chk("t3_spin_ip", ip, 8'h00);

    // Back-pressure during ISSUE.
    do_reset();
    mem[8'h00] = 8'h21;
    issue_ready = 1'b0;
    run = 1'b1;
    wait_issue("t4_op", 8'h21, 8'h00, 3, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_hold%0d_valid", i), instr_valid, 1'b1);
      chk($sformatf("t4_hold%0d_instr", i), instruction, 8'h21);
      chk($sformatf("t4_hold%0d_req", i), mem_req, 1'b0);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    chk("t4_accept_valid", instr_valid, 1'b0);
    chk("t4_accept_req", mem_req, 1'b1);
    chk("t4_accept_ip", ip, 8'h01);
    run = 1'b0;

    // IP wrap between opcode and immediate.
    do_reset();
    mem[8'h00] = 8'h80;
    mem[8'h01] = 8'hFF;
    mem[8'hFF] = 8'h48;
    run = 1'b1;
    wait_issue("t5_jump", 8'h80, 8'hFF, 5, 2);
    mem[8'h00] = 8'h07;
    wait_issue("t5_wrap", 8'h48, 8'h07, 5, 2);
    chk("t5_ip", ip, 8'h01);
    run = 1'b0;

    // Reset mid-fetch with 3-cycle memory; stale strobe arrives in IDLE.
    do_reset();
    lat = 3;
    mem[8'h00] = 8'h33;
    run = 1'b1;
    @(negedge clk);
    chk("t6_req_start", mem_req, 1'b1);
    run = 1'b0;
    @(negedge clk);
    chk("t6_req_wait", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t6_stale_req", mem_req, 1'b0);
      chk("t6_stale_valid", instr_valid, 1'b0);
      chk("t6_stale_ip", ip, 8'h00);
    end
    lat = 1;
    run = 1'b1;
    wait_issue("t6_restart", 8'h33, 8'h00, 3, 1);
    chk("t6_ip", ip, 8'h01);
    run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
